fp_normalize_pipe: RTL and testbench

//   Multi-lane, 2-stage pipelined normaliser/rounder/packer for MAC-array accumulator outputs.
//   Per lane: {sign, biased exponent, unnormalised raw mantissa} -> packed float (default bf16).

---
 rtl/tpu_fp_pkg.sv | 22 ++
 rtl/fp_lzc.sv | 26 ++
 rtl/fp_normalize_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_fp_pkg.sv
// Shared types and helpers for the accumulator-output float packing path.
package tpu_fp_pkg;

  // Rounding selection carried alongside each transaction.
  typedef enum logic {
    RND_RNE     = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  // Per-lane exception/status bits.
  typedef struct packed {
    logic ovf;
    logic unf;
    logic inexact;
  } fp_flags_t;

  // Exponent bias for an exp_w-bit biased exponent field.
  function automatic int fp_bias(input int exp_w);
    return (32'sd1 << (exp_w - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter with an all-zero indication.
module fp_lzc #(
  parameter int W = 16
) (
  input  logic [W-1:0]         i_data,
  output logic [$clog2(W):0]   o_cnt,
  output logic                 o_zero
);

  localparam int CW = $clog2(W) + 1;

  // Scan upward so the highest set bit is the last one to set the count.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_cnt = CW'(W - 1 - i);
      end else begin
        o_cnt = o_cnt;
      end
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage per-lane normaliser / rounder / packer for MAC accumulator outputs.
// Stage 1 normalises (LZC + shift + exponent adjust); stage 2 rounds, handles
// carry-out, saturates/flushes and packs into the output register bank.
module fp_normalize_pipe
  import tpu_fp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int RAW_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_rnd_mode,
  input  logic [LANES-1:0]               in_sign,
  input  logic [LANES*(EXP_W+1)-1:0]     in_exp,
  input  logic [LANES*RAW_W-1:0]         in_mant,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_data,
  output logic [LANES-1:0]               out_ovf,
  output logic [LANES-1:0]               out_unf,
  output logic [LANES-1:0]               out_inexact,
  output logic [2:0]                     sticky_flags
);

  localparam int EI_W   = EXP_W + 1;          // input exponent width
  localparam int E_W    = EXP_W + 3;          // signed working exponent width
  localparam int CW     = $clog2(RAW_W) + 1;  // LZC count width
  localparam int FRAC_W = RAW_W - 1;          // bits below the leading one
  localparam int OUT_W  = 1 + EXP_W + MAN_W;

  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = E_W'(0);

  // Handshake control
  logic r_s1_valid;
  logic r_out_valid;
  logic w_s2_en;
  logic w_s1_en;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_en   = !r_out_valid || out_ready;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign w_s1_load = in_valid && w_s1_en;
  assign w_s2_load = r_s1_valid && w_s2_en;
  assign in_ready  = w_s1_en;

  // Stage-1 register bank
  rnd_mode_e                         r_s1_rnd;
  logic [LANES-1:0]                  r_s1_sign;
  logic [LANES-1:0]                  r_s1_zero;
  logic [LANES-1:0][FRAC_W-1:0]      r_s1_frac;
  logic [LANES-1:0][E_W-1:0]         r_s1_e;

  // Stage-1 combinational results per lane
  logic [LANES-1:0]                  w_zero_all;
  logic [LANES-1:0][FRAC_W-1:0]      w_frac_all;
  logic [LANES-1:0][E_W-1:0]         w_e_all;

  // Stage-2 combinational results per lane
  logic [LANES-1:0][OUT_W-1:0]       w_pack_all;
  logic [LANES-1:0]                  w_ovf_all;
  logic [LANES-1:0]                  w_unf_all;
  logic [LANES-1:0]                  w_inex_all;

  // Output register bank
  logic [LANES*OUT_W-1:0]            r_out_data;
  logic [LANES-1:0]                  r_out_ovf;
  logic [LANES-1:0]                  r_out_unf;
  logic [LANES-1:0]                  r_out_inex;
  logic [2:0]                        r_sticky;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [RAW_W-1:0]        w_mant;
    logic [EI_W-1:0]         w_exp;
    logic [CW-1:0]           w_lzc;
    logic                    w_zero;

    logic [MAN_W-1:0]        w_kept;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_inc;
    logic [MAN_W:0]          w_sum;
    logic [MAN_W-1:0]        w_man;
    logic signed [E_W-1:0]   w_er;
    logic [OUT_W-1:0]        w_pack;
    fp_flags_t               w_flg;

    assign w_mant = in_mant[l*RAW_W +: RAW_W];
    assign w_exp  = in_exp[l*EI_W +: EI_W];

    fp_lzc #(.W(RAW_W)) u_lzc (
      .i_data (w_mant),
      .o_cnt  (w_lzc),
      .o_zero (w_zero)
    );

    // Leading one moves to the implicit position; only the bits below it are kept.
    // Exponent = in_exp + (p - (RAW_W-2)) with p = RAW_W-1-lzc, i.e. in_exp + 1 - lzc.
    assign w_frac_all[l] = FRAC_W'(w_mant << w_lzc);
    assign w_e_all[l]    = {2'b00, w_exp} + E_W'(1) - {{(E_W-CW){1'b0}}, w_lzc};
    assign w_zero_all[l] = w_zero;

    assign w_kept   = r_s1_frac[l][FRAC_W-1 -: MAN_W];
    assign w_guard  = r_s1_frac[l][FRAC_W-1-MAN_W];
    assign w_sticky = |r_s1_frac[l][FRAC_W-2-MAN_W:0];

    // Round-increment decision for the selected rounding mode.
    always_comb begin
      w_inc = 1'b0;
      case (r_s1_rnd)
        RND_RNE:     w_inc = w_guard && (w_sticky || w_kept[0]);
        RND_HALF_UP: w_inc = w_guard;
        default:     w_inc = 1'b0;
      endcase
    end

    assign w_sum = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_inc};

    // Carry-out renormalisation followed by saturation / flush / pack.
    always_comb begin
      w_man  = w_sum[MAN_W-1:0];
      w_er   = $signed(r_s1_e[l]);
      w_pack = '0;
      w_flg  = '0;
      if (w_sum[MAN_W]) begin
        w_man = '0;
        w_er  = $signed(r_s1_e[l]) + $signed(E_W'(1));
      end else begin
        w_man = w_sum[MAN_W-1:0];
        w_er  = $signed(r_s1_e[l]);
      end
      if (r_s1_zero[l]) begin
        w_pack = {r_s1_sign[l], {(OUT_W-1){1'b0}}};
        w_flg  = '0;
      end else if (w_er >= E_MAX) begin
        w_pack = {r_s1_sign[l], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_flg  = '{ovf: 1'b1, unf: 1'b0, inexact: 1'b1};
      end else if (w_er <= E_ZERO) begin
        w_pack = {r_s1_sign[l], {(OUT_W-1){1'b0}}};
        w_flg  = '{ovf: 1'b0, unf: 1'b1, inexact: 1'b1};
      end else begin
        w_pack = {r_s1_sign[l], w_er[EXP_W-1:0], w_man};
        w_flg  = '{ovf: 1'b0, unf: 1'b0, inexact: w_guard | w_sticky};
      end
    end

    assign w_pack_all[l] = w_pack;
    assign w_ovf_all[l]  = w_flg.ovf;
    assign w_unf_all[l]  = w_flg.unf;
    assign w_inex_all[l] = w_flg.inexact;
  end

  // Stage-1 occupancy: refills (or empties) whenever the stage may move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
    end
  end

  // Stage-1 payload captured on input handshake, rounding mode travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_rnd  <= RND_RNE;
      r_s1_sign <= '0;
      r_s1_zero <= '0;
      r_s1_frac <= '0;
      r_s1_e    <= '0;
    end else if (w_s1_load) begin
      r_s1_rnd  <= rnd_mode_e'(in_rnd_mode);
      r_s1_sign <= in_sign;
      r_s1_zero <= w_zero_all;
      r_s1_frac <= w_frac_all;
      r_s1_e    <= w_e_all;
    end
  end

  // Output occupancy: held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
    end
  end

  // Output payload loaded only when a stage-1 result moves forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_ovf  <= '0;
      r_out_unf  <= '0;
      r_out_inex <= '0;
    end else if (w_s2_load) begin
      r_out_data <= w_pack_all;
      r_out_ovf  <= w_ovf_all;
      r_out_unf  <= w_unf_all;
      r_out_inex <= w_inex_all;
    end
  end

  // Sticky status accumulates only results actually delivered downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 3'b000;
    end else if (r_out_valid && out_ready) begin
      r_sticky <= r_sticky | {|r_out_ovf, |r_out_unf, |r_out_inex};
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_ovf      = r_out_ovf;
  assign out_unf      = r_out_unf;
  assign out_inexact  = r_out_inex;
  assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed + model-checked bench for fp_normalize_pipe (bf16 defaults).
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_rnd_mode = 1'b0;
  logic [3:0]  in_sign = 4'h0;
  logic [35:0] in_exp = 36'h0;
  logic [63:0] in_mant = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  out_ovf;
  logic [3:0]  out_unf;
  logic [3:0]  out_inexact;
  logic [2:0]  sticky_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_normalize_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rnd_mode  (in_rnd_mode),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ovf      (out_ovf),
    .out_unf      (out_unf),
    .out_inexact  (out_inexact),
    .sticky_flags (sticky_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rnd;
    logic        sign;
    logic [8:0]  exp;
    logic [15:0] mant;
    logic [15:0] data;
    logic [2:0]  flags;   // {ovf, unf, inexact}
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  inex;
  } res_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference bf16 conversion: returns {ovf, unf, inexact, data[15:0]}.
  function automatic logic [18:0] lane_model(input logic s, input logic [8:0] e,
                                             input logic [15:0] m, input logic r);
    int p, ex, kept, rem, g, st, inc;
    logic o, u, x;
    logic [15:0] d;
    if (m == 16'h0000) return {3'b000, s, 15'h0000};
    p = 15;
    while (m[p] == 1'b0) p--;
    ex = int'(e) + p - 14;
    if (p >= 8) begin
      kept = (int'(m) >> (p - 7)) & 127;
      rem  = int'(m) & ((1 << (p - 7)) - 1);
      g    = (rem >> (p - 8)) & 1;
      st   = ((rem & ((1 << (p - 8)) - 1)) != 0) ? 1 : 0;
    end else begin
      kept = (int'(m) << (7 - p)) & 127;
      g    = 0;
      st   = 0;
    end
    inc = r ? g : (g & (st | (kept & 1)));
    kept = kept + inc;
    if (kept == 128) begin
      kept = 0;
      ex   = ex + 1;
    end
    if (ex >= 255) begin
      o = 1'b1; u = 1'b0; x = 1'b1; d = {s, 8'hFF, 7'h00};
    end else if (ex <= 0) begin
      o = 1'b0; u = 1'b1; x = 1'b1; d = {s, 15'h0000};
    end else begin
      o = 1'b0; u = 1'b0; x = (g | st) != 0; d = {s, ex[7:0], kept[6:0]};
    end
    return {o, u, x, d};
  endfunction

  // Randomise lanes lo..3, then predict all four lanes from the driven inputs.
  task automatic load_and_predict(input logic rnd, input int lo, output res_t r);
    logic [18:0] m;
    in_rnd_mode = rnd;
    for (int l = lo; l < 4; l++) begin
      in_sign[l]         = 1'($urandom_range(0, 1));
      in_exp[l*9 +: 9]   = 9'($urandom_range(0, 300));
      in_mant[l*16 +: 16] = 16'($urandom);
    end
    for (int l = 0; l < 4; l++) begin
      m = lane_model(in_sign[l], in_exp[l*9 +: 9], in_mant[l*16 +: 16], rnd);
      r.data[l*16 +: 16] = m[15:0];
      r.ovf[l]  = m[18];
      r.unf[l]  = m[17];
      r.inex[l] = m[16];
    end
  endtask

  task automatic check_result(input string nm, input res_t r);
    check({nm, "_data"}, out_data, r.data);
    check({nm, "_ovf"},  64'(out_ovf), 64'(r.ovf));
    check({nm, "_unf"},  64'(out_unf), 64'(r.unf));
    check({nm, "_inex"}, 64'(out_inexact), 64'(r.inex));
  endtask

  // Stream 8 transactions; optional out_ready pattern 1,1,0,0,...
  task automatic run_stream(input bit toggle);
    res_t q[$];
    int   got = 0;
    int   first = -1;
    int   last = -1;
    int   stalls = 0;
    bit   done = 1'b0;
    out_ready = 1'b1;
    fork
      begin : drv
        res_t r;
        bit   acc;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
          load_and_predict(1'($urandom_range(0, 1)), 0, r);
          in_valid = 1'b1;
          acc = 1'b0;
          for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
              acc = 1'b1;
              break;
            end else begin
              stalls++;
            end
          end
          check("stream_accept", 64'(acc), 64'(1));
          q.push_back(r);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : mon
        bit          pstall = 1'b0;
        logic [63:0] pdata = 64'h0;
        res_t        e;
        for (int c = 0; c < 120 && got < 8; c++) begin
          @(negedge clk);
          if (pstall) begin
            check("stall_hold_valid", 64'(out_valid), 64'(1));
            check("stall_hold_data", out_data, pdata);
          end
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              check("stream_unexpected_output", 64'(1), 64'(0));
            end else begin
              e = q.pop_front();
              check_result($sformatf("stream%0d", got), e);
            end
            got++;
            if (first < 0) first = c;
            last = c;
          end
          pstall = out_valid && !out_ready;
          pdata  = out_data;
        end
        done = 1'b1;
      end
      begin : rdy
        int c = 0;
        while (!done) begin
          @(posedge clk); #1;
          if (toggle) out_ready = ((c % 4) < 2);
          c++;
        end
        out_ready = 1'b1;
      end
    join
    check("stream_count", 64'(got), 64'(8));
    if (!toggle) begin
      check("throughput_span", 64'(last - first), 64'(7));
      check("throughput_no_stall", 64'(stalls), 64'(0));
    end
    repeat (3) @(posedge clk);
    #1;
    check("stream_no_extra", 64'(out_valid), 64'(0));
  endtask

  vec_t vecs[20];
  res_t r;

  initial begin
    vecs = '{
      '{1'b0, 1'b0, 9'd127, 16'h4000, 16'h3F80, 3'b000},
      '{1'b0, 1'b0, 9'd127, 16'h8000, 16'h4000, 3'b000},
      '{1'b0, 1'b0, 9'd127, 16'h2000, 16'h3F00, 3'b000},
      '{1'b0, 1'b0, 9'd127, 16'h4040, 16'h3F80, 3'b001},
      '{1'b1, 1'b0, 9'd127, 16'h4040, 16'h3F81, 3'b001},
      '{1'b0, 1'b0, 9'd127, 16'h7FFF, 16'h4000, 3'b001},
      '{1'b0, 1'b0, 9'd254, 16'h8000, 16'h7F80, 3'b101},
      '{1'b0, 1'b0, 9'd1,   16'h2000, 16'h0000, 3'b011},
      '{1'b0, 1'b1, 9'd127, 16'h4000, 16'hBF80, 3'b000},
      '{1'b0, 1'b0, 9'd200, 16'h0000, 16'h0000, 3'b000},
      '{1'b0, 1'b1, 9'd5,   16'h0000, 16'h8000, 3'b000},
      '{1'b0, 1'b0, 9'd127, 16'h40C0, 16'h3F82, 3'b001},
      '{1'b0, 1'b0, 9'd127, 16'h4041, 16'h3F81, 3'b001},
      '{1'b0, 1'b0, 9'd254, 16'h7FFF, 16'h7F80, 3'b101},
      '{1'b0, 1'b0, 9'd253, 16'h8000, 16'h7F00, 3'b000},
      '{1'b0, 1'b0, 9'd0,   16'h8000, 16'h0080, 3'b000},
      '{1'b0, 1'b0, 9'd140, 16'h0001, 16'h3F00, 3'b000},
      '{1'b0, 1'b1, 9'd300, 16'h4000, 16'hFF80, 3'b101},
      '{1'b0, 1'b1, 9'd0,   16'h4000, 16'h8000, 3'b011},
      '{1'b1, 1'b0, 9'd127, 16'h7FC0, 16'h4000, 3'b001}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", out_data, 64'h0);
    check("rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'(0));
    check("rst_sticky", 64'(sticky_flags), 64'(0));
    rst_n = 1'b1;

    // Directed lane-0 vectors, other lanes random and model-checked
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_sign[0]     = vecs[i].sign;
      in_exp[8:0]    = vecs[i].exp;
      in_mant[15:0]  = vecs[i].mant;
      load_and_predict(vecs[i].rnd, 1, r);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_early", i), 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_lane0", i), 64'(out_data[15:0]), 64'(vecs[i].data));
      check($sformatf("vec%0d_lane0_flags", i),
            64'({out_ovf[0], out_unf[0], out_inexact[0]}), 64'(vecs[i].flags));
      check_result($sformatf("vec%0d", i), r);
    end
    @(posedge clk); #1;
    check("sticky_all", 64'(sticky_flags), 64'(3'b111));

    // Back-pressure stream, then full-rate stream
    run_stream(1'b1);
    run_stream(1'b0);

    // Reset with two transactions in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    load_and_predict(1'b0, 0, r);
    in_valid = 1'b1;
    @(posedge clk); #1;
    load_and_predict(1'b0, 0, r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_sticky", 64'(sticky_flags), 64'(0));
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    check("rst_mid_data", out_data, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_empty", 64'(out_valid), 64'(0));
    load_and_predict(1'b1, 0, r);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_lat1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("post_rst_lat2", 64'(out_valid), 64'(1));
    check_result("post_rst", r);
    @(posedge clk); #1;
    check("post_rst_drained", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
